// File: rtl/mem_bus_pkg.sv
// Shared memory-bus definitions: responder state encoding, strobe codes, widths.
package mem_bus_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 16;

  localparam logic [1:0] WSTRB_READ = 2'b00;
  localparam logic [1:0] WSTRB_LO   = 2'b01;
  localparam logic [1:0] WSTRB_HI   = 2'b10;
  localparam logic [1:0] WSTRB_WORD = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } mem_resp_state_t;

endpackage

// File: rtl/mem_responder_if.sv
// Core memory-port bundle; master = initiator (core), slave = responder.
interface mem_responder_if;
  import mem_bus_pkg::*;

  logic              mem_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [1:0]        mem_wstrb;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;
  logic              wp_err;

  modport master (
    output mem_valid, mem_addr, mem_wstrb, mem_wdata,
    input  mem_ready, mem_rdata, wp_err
  );

  modport slave (
    input  mem_valid, mem_addr, mem_wstrb, mem_wdata,
    output mem_ready, mem_rdata, wp_err
  );

endinterface

// File: rtl/mem_array.sv
// Single-port word array with per-byte write enables and a registered read port.
module mem_array
  import mem_bus_pkg::*;
#(
  parameter int unsigned DEPTH = 4096
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rd_en,
  input  logic [1:0]               we,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents are deliberately not reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we[0]) mem[idx][7:0]  <= wdata[7:0];
    if (we[1]) mem[idx][15:8] <= wdata[15:8];
  end

  always_ff @(posedge clk) begin
    if (rst)        rdata <= '0;
    else if (rd_en) rdata <= mem[idx];
  end

endmodule

// File: rtl/mem_responder.sv
// Wait-state memory responder for the core port. Define MEM_RESPONDER_WP_EN to
// write-protect indices below ROM_WORDS (suppressed write + wp_err pulse).
//
// state | meaning
// IDLE  | waiting for mem_valid; request fields captured on acceptance
// WAIT  | wait counter running down toward the commit edge
// RESP  | one-cycle mem_ready (and wp_err if the write was blocked)
module mem_responder
  import mem_bus_pkg::*;
#(
  parameter int unsigned DEPTH       = 4096,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned ROM_WORDS   = 256
) (
  input  logic           clk,
  input  logic           rst,
  mem_responder_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

`ifdef MEM_RESPONDER_WP_EN
  localparam bit WP_EN = 1'b1;
`else
  localparam bit WP_EN = 1'b0;
`endif

  mem_resp_state_t state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic [IDX_W-1:0]  idx_q;
  logic [1:0]        wstrb_q;
  logic [DATA_W-1:0] wdata_q;
  logic              wp_q;
  logic              accept;
  logic              commit;

  logic [IDX_W-1:0]  idx_in;
  logic              prot_in;
  logic [IDX_W-1:0]  cur_idx;
  logic [1:0]        cur_wstrb;
  logic [DATA_W-1:0] cur_wdata;
  logic              cur_wp;
  logic              arr_rd;
  logic [1:0]        arr_we;
  logic              unused_addr;

  assign idx_in      = bus.mem_addr[IDX_W-1:0];
  assign unused_addr = ^bus.mem_addr;
  assign prot_in     = WP_EN && (bus.mem_wstrb != WSTRB_READ) &&
                       (32'(idx_in) < ROM_WORDS);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      idx_q   <= '0;
      wstrb_q <= WSTRB_READ;
      wdata_q <= '0;
      wp_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        idx_q   <= idx_in;
        wstrb_q <= bus.mem_wstrb;
        wdata_q <= bus.mem_wdata;
        wp_q    <= prot_in;
      end
    end
  end

  // commit marks the edge that enters RESP: array access happens there.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    commit    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.mem_valid) begin
          accept  = 1'b1;
          cnt_nxt = 4'(WAIT_CYCLES);
          if (WAIT_CYCLES == 0) begin
            state_nxt = RESP;
            commit    = 1'b1;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_nxt = RESP;
          commit    = 1'b1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // With zero wait states the commit edge is also the acceptance edge.
  assign cur_idx   = (state == IDLE) ? idx_in        : idx_q;
  assign cur_wstrb = (state == IDLE) ? bus.mem_wstrb : wstrb_q;
  assign cur_wdata = (state == IDLE) ? bus.mem_wdata : wdata_q;
  assign cur_wp    = (state == IDLE) ? prot_in       : wp_q;

  assign arr_rd = commit && !rst && (cur_wstrb == WSTRB_READ);
  assign arr_we = (commit && !rst && !cur_wp) ? cur_wstrb : WSTRB_READ;

  mem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .rd_en (arr_rd),
    .we    (arr_we),
    .idx   (cur_idx),
    .wdata (cur_wdata),
    .rdata (bus.mem_rdata)
  );

  assign bus.mem_ready = (state == RESP);
  assign bus.wp_err    = (state == RESP) && wp_q;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder against a word-array reference model.
module tb_mem_responder;
  import mem_bus_pkg::*;

  localparam int unsigned DEPTH       = 4096;
  localparam int unsigned WAIT_CYCLES = 2;
  localparam int unsigned ROM_WORDS   = 256;

`ifdef MEM_RESPONDER_WP_EN
  localparam bit WP_EN_TB = 1'b1;
`else
  localparam bit WP_EN_TB = 1'b0;
`endif

  logic clk;
  logic rst;
  mem_responder_if bus ();

  mem_responder #(
    .DEPTH       (DEPTH),
    .WAIT_CYCLES (WAIT_CYCLES),
    .ROM_WORDS   (ROM_WORDS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] model [DEPTH];
  bit          known [DEPTH];
  logic [15:0] last_rd;
  bit          last_known;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge one cycle after mem_ready.
  task automatic txn(input logic [15:0] addr, input logic [1:0] wstrb,
                     input logic [15:0] wdata, input string tag,
                     output logic [15:0] rd);
    int idx;
    int n;
    bit seen;
    bit exp_wp;
    idx    = int'(addr[11:0]);
    exp_wp = WP_EN_TB && (wstrb != 2'b00) && (idx < int'(ROM_WORDS));
    bus.mem_valid = 1'b1;
    bus.mem_addr  = addr;
    bus.mem_wstrb = wstrb;
    bus.mem_wdata = wdata;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (bus.mem_ready) seen = 1'b1;
      else begin
        bus.mem_addr  = 16'($urandom);
        bus.mem_wstrb = 2'($urandom);
        bus.mem_wdata = 16'($urandom);
      end
    end
    rd = bus.mem_rdata;
    if (!seen) begin
      check_val({tag, " ready_timeout"}, 32'(n), 32'(1 + WAIT_CYCLES));
      bus.mem_valid = 1'b0;
      return;
    end
    check_val({tag, " latency"}, 32'(n), 32'(1 + WAIT_CYCLES));
    check_val({tag, " wp_err"}, 32'(bus.wp_err), 32'(exp_wp));
    if (wstrb == 2'b00) begin
      if (known[idx]) check_val({tag, " rdata"}, 32'(bus.mem_rdata), 32'(model[idx]));
      last_rd    = model[idx];
      last_known = known[idx];
    end else begin
      if (last_known) check_val({tag, " rdata_kept"}, 32'(bus.mem_rdata), 32'(last_rd));
      if (!exp_wp) begin
        if (wstrb[0]) model[idx][7:0]  = wdata[7:0];
        if (wstrb[1]) model[idx][15:8] = wdata[15:8];
        if (wstrb == 2'b11) known[idx] = 1'b1;
      end
    end
    bus.mem_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_val({tag, " ready_pulse"}, 32'(bus.mem_ready), 32'd0);
    check_val({tag, " wp_after"}, 32'(bus.wp_err), 32'd0);
    if (last_known) check_val({tag, " rdata_hold"}, 32'(bus.mem_rdata), 32'(last_rd));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rd;
    logic [15:0] r0;
    int          idx;
    logic [15:0] addr;

    for (int i = 0; i < int'(DEPTH); i++) known[i] = 1'b0;
    rst           = 1'b1;
    bus.mem_valid = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wstrb = WSTRB_READ;
    bus.mem_wdata = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_val("reset ready", 32'(bus.mem_ready), 32'd0);
      check_val("reset rdata", 32'(bus.mem_rdata), 32'd0);
      check_val("reset wp_err", 32'(bus.wp_err), 32'd0);
    end
    last_rd    = 16'h0000;
    last_known = 1'b1;

    for (int i = 'h100; i < 'h140; i++)
      txn(16'(i), WSTRB_WORD, 16'($urandom), "init", rd);
    txn(16'h0200, WSTRB_WORD, 16'h5A5A, "init200", rd);

    txn(16'h0123, WSTRB_WORD, 16'hBEEF, "wr_word", rd);
    txn(16'h0123, WSTRB_READ, 16'h0000, "rd_word", rd);
    check_val("rd_word const", 32'(rd), 32'h0000_BEEF);
    txn(16'h0123, WSTRB_LO, 16'h0055, "wr_lo", rd);
    txn(16'h0123, WSTRB_READ, 16'h0000, "rd_lo", rd);
    check_val("rd_lo const", 32'(rd), 32'h0000_BE55);
    txn(16'h0123, WSTRB_HI, 16'h1200, "wr_hi", rd);
    txn(16'h0123, WSTRB_READ, 16'h0000, "rd_hi", rd);
    check_val("rd_hi const", 32'(rd), 32'h0000_1255);
    txn(16'h1123, WSTRB_WORD, 16'hCAFE, "wr_wrap", rd);
    txn(16'h0123, WSTRB_READ, 16'h0000, "rd_wrap", rd);
    check_val("rd_wrap const", 32'(rd), 32'h0000_CAFE);

    if (WP_EN_TB) begin
      txn(16'h0010, WSTRB_READ, 16'h0000, "wp_pre", r0);
      txn(16'h0010, WSTRB_WORD, 16'h1234, "wp_wr", rd);
      txn(16'h0010, WSTRB_READ, 16'h0000, "wp_post", rd);
      check_val("wp unchanged", 32'(rd), 32'(r0));
    end else begin
      txn(16'h0010, WSTRB_WORD, 16'h1234, "nowp_wr", rd);
      txn(16'h0010, WSTRB_READ, 16'h0000, "nowp_rd", rd);
      check_val("nowp const", 32'(rd), 32'h0000_1234);
    end

    // Reset lands on the cycle before the commit edge.
    bus.mem_valid = 1'b1;
    bus.mem_addr  = 16'h0200;
    bus.mem_wstrb = WSTRB_WORD;
    bus.mem_wdata = 16'hAAAA;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_val("mid pre_ready", 32'(bus.mem_ready), 32'd0);
    end
    rst           = 1'b1;
    bus.mem_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_val("mid rst_ready", 32'(bus.mem_ready), 32'd0);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_val("mid post_ready", 32'(bus.mem_ready), 32'd0);
    end
    check_val("mid rdata_rst", 32'(bus.mem_rdata), 32'd0);
    last_rd    = 16'h0000;
    last_known = 1'b1;
    txn(16'h0200, WSTRB_READ, 16'h0000, "mid rd", rd);
    check_val("mid discarded", 32'(rd), 32'h0000_5A5A);

    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 4) == 0) idx = int'($urandom_range(0, 63));
      else                           idx = 'h100 + int'($urandom_range(0, 63));
      addr = {4'($urandom), 12'(idx)};
      txn(addr, 2'($urandom), 16'($urandom), "rand", rd);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        @(negedge clk);
        check_val("rand idle_ready", 32'(bus.mem_ready), 32'd0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
